// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline latch and FETCH/HALTED control.
// Define IF_SKID_BUFFER_EN to add a one-entry skid buffer that captures hits arriving during a stall.
module if_fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

`ifdef IF_SKID_BUFFER_EN
    logic        skid_full_q, skid_full_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
`ifdef IF_SKID_BUFFER_EN
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
`endif
        case (state_q)
            FETCH: begin
                // Priority: redirect, then halt, then stall, then a cache hit.
                if (redirect_en) begin
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    valid_d = 1'b0;
                    instr_d = 32'h0;
`ifdef IF_SKID_BUFFER_EN
                    skid_full_d = 1'b0;
`endif
                end else if (halt && valid_q) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                end else if (stall) begin
`ifdef IF_SKID_BUFFER_EN
                    if (ihit && !skid_full_q) begin
                        skid_full_d  = 1'b1;
                        skid_instr_d = imemload;
                        skid_pc4_d   = pc_plus4;
                        pc_d         = pc_plus4;
                    end
`endif
                end
`ifdef IF_SKID_BUFFER_EN
                else if (skid_full_q) begin
                    instr_d     = skid_instr_q;
                    pc4_d       = skid_pc4_q;
                    valid_d     = 1'b1;
                    skid_full_d = 1'b0;
                end
`endif
                else if (ihit) begin
                    instr_d = imemload;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    instr_d = 32'h0;
                    valid_d = 1'b0;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                instr_d = 32'h0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
`ifdef IF_SKID_BUFFER_EN
            skid_full_q  <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
`ifdef IF_SKID_BUFFER_EN
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
`endif
        end
    end

`ifdef IF_SKID_BUFFER_EN
    assign imemREN = (state_q == FETCH) && !skid_full_q;
`else
    assign imemREN = (state_q == FETCH);
`endif

    assign imemaddr = pc_q;
    assign instr    = instr_q;
    assign pc4      = pc4_q;
    assign valid    = valid_q;

endmodule
